// File: rtl/window_line_buffer_if.sv
// Pixel-in / window-out handshake bundle for window_line_buffer.
// master drives pixels and consumer ready; slave is the line buffer.
interface window_line_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int KSIZE      = 3
);
  logic [DATA_WIDTH-1:0]               inPixel;
  logic                                inPixelValid;
  logic                                inPixelReady;
  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   outWindow;
  logic                                outWindowValid;
  logic                                outWindowReady;
  logic [$clog2(IMG_HEIGHT)-1:0]       outRow;
  logic [$clog2(IMG_WIDTH)-1:0]        outCol;
  logic                                frameDone;

  modport master (
    output inPixel, inPixelValid, outWindowReady,
    input  inPixelReady, outWindow, outWindowValid, outRow, outCol, frameDone
  );

  modport slave (
    input  inPixel, inPixelValid, outWindowReady,
    output inPixelReady, outWindow, outWindowValid, outRow, outCol, frameDone
  );
endinterface

// File: rtl/window_line_buffer.sv
// Raster-order KxK sliding window generator, valid-only borders; window registered one cycle after its last pixel.
// Input stalls only when an unconsumed window is held and the consumer is not ready.
module window_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int KSIZE      = 3
) (
  input  logic              clk,
  input  logic              rst,
  window_line_buffer_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int WW = KSIZE*KSIZE*DATA_WIDTH;

  // r_line[0] is the oldest stored line, r_line[KSIZE-2] the line just above the current one
  logic [DATA_WIDTH-1:0] r_line  [KSIZE-1][IMG_WIDTH];
  // r_shift[r][0..KSIZE-2] holds the KSIZE-1 columns left of the current pixel, oldest first
  logic [DATA_WIDTH-1:0] r_shift [KSIZE][KSIZE-1];

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic                  r_valid;
  logic                  r_done;
  logic [WW-1:0]         r_window;
  logic [RW-1:0]         r_out_row;
  logic [CW-1:0]         r_out_col;

  logic                  w_ready;
  logic                  w_xfer;
  logic                  w_in_win;
  logic                  w_last_col;
  logic                  w_last_row;
  logic [DATA_WIDTH-1:0] w_new_col [KSIZE];
  logic [WW-1:0]         w_window;

  assign w_ready    = !r_valid || bus.outWindowReady;
  assign w_xfer     = bus.inPixelValid && w_ready && rst;
  assign w_last_col = (r_col == CW'(IMG_WIDTH-1));
  assign w_last_row = (r_row == RW'(IMG_HEIGHT-1));
  assign w_in_win   = (r_row >= RW'(KSIZE-1)) && (r_col >= CW'(KSIZE-1));

  always_comb begin
    for (int r = 0; r < KSIZE-1; r++) begin
      w_new_col[r] = r_line[r][r_col];
    end
    w_new_col[KSIZE-1] = bus.inPixel;
  end

  always_comb begin
    w_window = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE-1; c++) begin
        w_window[(KSIZE*KSIZE-1-(r*KSIZE+c))*DATA_WIDTH +: DATA_WIDTH] = r_shift[r][c];
      end
      w_window[(KSIZE*KSIZE-1-(r*KSIZE+KSIZE-1))*DATA_WIDTH +: DATA_WIDTH] = w_new_col[r];
    end
  end

  // Storage is deliberately not reset; border gating keeps stale contents out of windows.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      for (int i = 0; i < KSIZE-2; i++) begin
        r_line[i][r_col] <= r_line[i+1][r_col];
      end
      r_line[KSIZE-2][r_col] <= bus.inPixel;
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE-2; c++) begin
          r_shift[r][c] <= r_shift[r][c+1];
        end
        r_shift[r][KSIZE-2] <= w_new_col[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_window  <= '0;
      r_out_row <= '0;
      r_out_col <= '0;
    end else begin
      r_done <= w_xfer && w_last_col && w_last_row;
      if (w_xfer) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_xfer && w_in_win) begin
        r_valid   <= 1'b1;
        r_window  <= w_window;
        r_out_row <= r_row - RW'(KSIZE-1);
        r_out_col <= r_col - CW'(KSIZE-1);
      end else if (bus.outWindowReady) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.inPixelReady   = w_ready;
  assign bus.outWindow      = r_window;
  assign bus.outWindowValid = r_valid;
  assign bus.outRow         = r_out_row;
  assign bus.outCol         = r_out_col;
  assign bus.frameDone      = r_done;
endmodule
